// File: rtl/median_pkg.sv
// ============================================================================
// median_pkg : shared flag indices, FSM state type and source id type
//              for the median filter frame arbiter.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package median_pkg;

  localparam int FLG_SOF = 3;
  localparam int FLG_EOF = 2;
  localparam int FLG_SOL = 1;
  localparam int FLG_EOL = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  typedef logic src_id_t;

endpackage

`default_nettype wire

// File: rtl/median_id_fifo.sv
// ============================================================================
// median_id_fifo : synchronous FIFO of source ids for frames in flight
//                  through the median filter (DEPTH power of 2, min 2).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module median_id_fifo
  import median_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  src_id_t push_id,
  input  logic    pop,
  output src_id_t head_id,
  output logic    full,
  output logic    empty
);

  localparam int c_aw = $clog2(DEPTH);

  src_id_t          mem_q [DEPTH];
  src_id_t          mem_d [DEPTH];
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_aw:0]    count_q, count_d;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (count_q == (c_aw+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;
  assign head_id   = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = push_id;
      wr_ptr_d        = wr_ptr_q + c_aw'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + c_aw'(1);
    end
    // simultaneous push and pop leaves the occupancy unchanged
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + (c_aw+1)'(1);
      2'b01:   count_d = count_q - (c_aw+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

`default_nettype wire

// File: rtl/median_frame_arb.sv
// ============================================================================
// median_frame_arb : frame-granular round-robin arbiter of two 3x3 window
//                    sources onto one median filter, with the filtered
//                    stream routed back to the consumer matching its source.
//                    Optional frame counters: define MEDIAN_ARB_STATS_EN.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module median_frame_arb
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ID_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s0_val,
  output logic                    s0_rdy,
  input  logic [9*DATA_WIDTH-1:0] s0_data,
  input  logic [3:0]              s0_flg,
  input  logic                    s1_val,
  output logic                    s1_rdy,
  input  logic [9*DATA_WIDTH-1:0] s1_data,
  input  logic [3:0]              s1_flg,
  output logic                    f_val,
  output logic [9*DATA_WIDTH-1:0] f_data,
  output logic [3:0]              f_flg,
  input  logic                    f_rdy,
  input  logic                    r_val,
  input  logic [DATA_WIDTH-1:0]   r_data,
  input  logic [3:0]              r_flg,
  output logic                    r_rdy,
  output logic                    m0_val,
  output logic [DATA_WIDTH-1:0]   m0_data,
  output logic [3:0]              m0_flg,
  input  logic                    m0_rdy,
  output logic                    m1_val,
  output logic [DATA_WIDTH-1:0]   m1_data,
  output logic [3:0]              m1_flg,
  input  logic                    m1_rdy
`ifdef MEDIAN_ARB_STATS_EN
  ,
  output logic [15:0]             frm_cnt0,
  output logic [15:0]             frm_cnt1
`endif
);

  arb_state_e state_q, state_d;
  src_id_t    last_q, last_d;
  logic       w_req0, w_req1;
  logic       w_push;
  src_id_t    w_push_id;
  logic       w_pop;
  src_id_t    w_head;
  logic       w_full, w_empty;

  assign w_req0 = s0_val & s0_flg[FLG_SOF];
  assign w_req1 = s1_val & s1_flg[FLG_SOF];

  median_id_fifo #(
    .DEPTH (ID_DEPTH)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .push_id (w_push_id),
    .pop     (w_pop),
    .head_id (w_head),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // last_q holds the most recent winner; a tie goes to the other source
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    w_push    = 1'b0;
    w_push_id = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!w_full) begin
          if (w_req0 && (!w_req1 || last_q == 1'b1)) begin
            state_d   = ST_GNT0;
            last_d    = 1'b0;
            w_push    = 1'b1;
            w_push_id = 1'b0;
          end else if (w_req1) begin
            state_d   = ST_GNT1;
            last_d    = 1'b1;
            w_push    = 1'b1;
            w_push_id = 1'b1;
          end
        end
      end
      ST_GNT0: begin
        if (s0_val && f_rdy && s0_flg[FLG_EOF]) state_d = ST_IDLE;
      end
      ST_GNT1: begin
        if (s1_val && f_rdy && s1_flg[FLG_EOF]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s0_rdy = 1'b0;
    s1_rdy = 1'b0;
    f_val  = 1'b0;
    f_data = '0;
    f_flg  = '0;
    case (state_q)
      ST_IDLE: begin
        // stray mid-frame beats are drained; sof beats wait for a grant
        s0_rdy = s0_val & ~s0_flg[FLG_SOF];
        s1_rdy = s1_val & ~s1_flg[FLG_SOF];
      end
      ST_GNT0: begin
        f_val  = s0_val;
        f_data = s0_data;
        f_flg  = s0_flg;
        s0_rdy = f_rdy;
      end
      ST_GNT1: begin
        f_val  = s1_val;
        f_data = s1_data;
        f_flg  = s1_flg;
        s1_rdy = f_rdy;
      end
      default: begin
        s0_rdy = 1'b0;
        s1_rdy = 1'b0;
      end
    endcase
  end

  always_comb begin
    m0_val  = 1'b0;
    m0_data = '0;
    m0_flg  = '0;
    m1_val  = 1'b0;
    m1_data = '0;
    m1_flg  = '0;
    r_rdy   = 1'b0;
    if (!w_empty) begin
      if (w_head == 1'b0) begin
        m0_val  = r_val;
        m0_data = r_data;
        m0_flg  = r_flg;
        r_rdy   = m0_rdy;
      end else begin
        m1_val  = r_val;
        m1_data = r_data;
        m1_flg  = r_flg;
        r_rdy   = m1_rdy;
      end
    end
  end

  assign w_pop = r_val & r_rdy & r_flg[FLG_EOF];

`ifdef MEDIAN_ARB_STATS_EN
  logic [15:0] frm_cnt0_q, frm_cnt0_d;
  logic [15:0] frm_cnt1_q, frm_cnt1_d;

  always_comb begin
    frm_cnt0_d = frm_cnt0_q + 16'(m0_val & m0_rdy & m0_flg[FLG_EOF]);
    frm_cnt1_d = frm_cnt1_q + 16'(m1_val & m1_rdy & m1_flg[FLG_EOF]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt0_q <= '0;
      frm_cnt1_q <= '0;
    end else begin
      frm_cnt0_q <= frm_cnt0_d;
      frm_cnt1_q <= frm_cnt1_d;
    end
  end

  assign frm_cnt0 = frm_cnt0_q;
  assign frm_cnt1 = frm_cnt1_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_median_frame_arb.sv
// ============================================================================
// tb_median_frame_arb : self-checking bench for median_frame_arb with a
//                       behavioural median filter and per-source scoreboards.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_median_frame_arb;
  import median_pkg::*;

  localparam int DW    = 8;
  localparam int WW    = 9 * DW;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s0_val = 1'b0, s1_val = 1'b0;
  logic          s0_rdy, s1_rdy;
  logic [WW-1:0] s0_data = '0, s1_data = '0;
  logic [3:0]    s0_flg = '0, s1_flg = '0;
  logic          f_val;
  logic [WW-1:0] f_data;
  logic [3:0]    f_flg;
  logic          f_rdy = 1'b0;
  logic          r_val = 1'b0;
  logic [DW-1:0] r_data = '0;
  logic [3:0]    r_flg = '0;
  logic          r_rdy;
  logic          m0_val, m1_val;
  logic [DW-1:0] m0_data, m1_data;
  logic [3:0]    m0_flg, m1_flg;
  logic          m0_rdy = 1'b0, m1_rdy = 1'b0;
`ifdef MEDIAN_ARB_STATS_EN
  logic [15:0]   frm_cnt0, frm_cnt1;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  median_frame_arb #(.DATA_WIDTH(DW), .ID_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s0_val(s0_val), .s0_rdy(s0_rdy), .s0_data(s0_data), .s0_flg(s0_flg),
    .s1_val(s1_val), .s1_rdy(s1_rdy), .s1_data(s1_data), .s1_flg(s1_flg),
    .f_val(f_val), .f_data(f_data), .f_flg(f_flg), .f_rdy(f_rdy),
    .r_val(r_val), .r_data(r_data), .r_flg(r_flg), .r_rdy(r_rdy),
    .m0_val(m0_val), .m0_data(m0_data), .m0_flg(m0_flg), .m0_rdy(m0_rdy),
    .m1_val(m1_val), .m1_data(m1_data), .m1_flg(m1_flg), .m1_rdy(m1_rdy)
`ifdef MEDIAN_ARB_STATS_EN
    , .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // expected windows per source, observed beats per stream
  logic [WW-1:0]   xw0[$], xw1[$];
  logic [3:0]      xf0[$], xf1[$];
  logic [WW-1:0]   fobs[$];
  int              fcyc[$];
  logic [DW+3:0]   mo0[$], mo1[$];
  int              f_first = -1, m0_first = -1, sof_cyc = 0;
  bit              m1_seen = 1'b0;

  bit              f_take = 1'b0, r_take = 1'b0, rst_s = 1'b1;
  logic [WW-1:0]   f_data_s = '0;
  logic [3:0]      f_flg_s = '0;
  logic [DW+3:0]   fq[$];
  int              r_pct = 100;
  bit              f_mode = 1'b0, m_mode = 1'b0;
  logic            f_rdy_man = 1'b0, m0_rdy_man = 1'b0, m1_rdy_man = 1'b0;

  function automatic logic [DW-1:0] med9(input logic [WW-1:0] w);
    logic [DW-1:0] p[9];
    logic [DW-1:0] t;
    for (int i = 0; i < 9; i++) p[i] = w[i*DW +: DW];
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8 - i; j++)
        if (p[j] > p[j+1]) begin t = p[j]; p[j] = p[j+1]; p[j+1] = t; end
    return p[4];
  endfunction

  always @(negedge clk) begin
    rst_s    = rst;
    f_take   = f_val & f_rdy;
    r_take   = r_val & r_rdy;
    f_data_s = f_data;
    f_flg_s  = f_flg;
    if (!rst) begin
      if (f_val && f_first < 0) f_first = cyc;
      if (f_take) begin fobs.push_back(f_data); fcyc.push_back(cyc); end
      if (m0_val && m0_rdy) begin
        mo0.push_back({m0_flg, m0_data});
        if (m0_first < 0) m0_first = cyc;
      end
      if (m1_val && m1_rdy) mo1.push_back({m1_flg, m1_data});
      if (m1_val) m1_seen = 1'b1;
    end
  end

  // behavioural median filter plus consumer ready generators
  always begin
    @(posedge clk); #1;
    if (rst_s) begin
      fq.delete();
      r_val = 1'b0;
    end else begin
      if (f_take) fq.push_back({f_flg_s, med9(f_data_s)});
      if (r_take) begin void'(fq.pop_front()); r_val = 1'b0; end
      if (!r_val && fq.size() > 0 && $urandom_range(0, 99) < r_pct) begin
        r_val = 1'b1;
        {r_flg, r_data} = fq[0];
      end
    end
    f_rdy  = f_mode ? 1'($urandom_range(0, 1)) : f_rdy_man;
    m0_rdy = m_mode ? 1'($urandom_range(0, 1)) : m0_rdy_man;
    m1_rdy = m_mode ? 1'($urandom_range(0, 1)) : m1_rdy_man;
  end

  task automatic clear_all();
    fobs.delete(); fcyc.delete(); mo0.delete(); mo1.delete();
    xw0.delete(); xw1.delete(); xf0.delete(); xf1.delete();
    f_first = -1; m0_first = -1; m1_seen = 1'b0;
  endtask

  task automatic set_rdy(input logic f, input logic a, input logic b, input int pct);
    f_mode = 1'b0; m_mode = 1'b0;
    f_rdy_man = f; m0_rdy_man = a; m1_rdy_man = b; r_pct = pct;
  endtask

  task automatic do_reset();
    rst = 1'b1; s0_val = 1'b0; s1_val = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    clear_all();
  endtask

  task automatic drive_beat(input int src, input logic [WW-1:0] d, input logic [3:0] fl,
                            output int n);
    bit t;
    n = 0; t = 1'b0;
    if (src == 0) begin s0_val = 1'b1; s0_data = d; s0_flg = fl; end
    else          begin s1_val = 1'b1; s1_data = d; s1_flg = fl; end
    while (!t && n < 400) begin
      @(negedge clk);
      t = (src == 0) ? s0_rdy : s1_rdy;
      @(posedge clk); #1;
      n++;
    end
    if (src == 0) s0_val = 1'b0; else s1_val = 1'b0;
    if (!t) begin
      checks++; failures++;
      $display("FAIL beat_handshake src=%0d got=timeout expected=accepted", src);
    end
  endtask

  task automatic send_frame(input int src, input int w, input int h, input int gap);
    logic [95:0]   rr;
    logic [WW-1:0] d;
    logic [3:0]    fl;
    int            n;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        rr = {$urandom, $urandom, $urandom};
        d  = rr[WW-1:0];
        fl = {r == 0 && c == 0, r == h-1 && c == w-1, c == 0, c == w-1};
        if (src == 0) begin xw0.push_back(d); xf0.push_back(fl); end
        else          begin xw1.push_back(d); xf1.push_back(fl); end
        if (!(r == 0 && c == 0) && gap > 0)
          repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
        if (r == 0 && c == 0) sof_cyc = cyc;
        drive_beat(src, d, fl, n);
      end
    end
  endtask

  task automatic wait_out(input int n0, input int n1);
    int k = 0;
    while ((mo0.size() < n0 || mo1.size() < n1) && k < 4000) begin
      @(posedge clk); #1; k++;
    end
    repeat (6) begin @(posedge clk); #1; end
    if (k >= 4000) begin
      checks++; failures++;
      $display("FAIL output_wait got_m0=%0d got_m1=%0d expected_m0=%0d expected_m1=%0d",
               mo0.size(), mo1.size(), n0, n1);
    end
  endtask

  // index of first consumer beat differing from median of the source window, or -1
  function automatic int stream_bad(input int src);
    int ne, no, mn;
    logic [DW+3:0] e, o;
    ne = (src == 0) ? xw0.size() : xw1.size();
    no = (src == 0) ? mo0.size() : mo1.size();
    mn = (ne < no) ? ne : no;
    for (int i = 0; i < mn; i++) begin
      e = (src == 0) ? {xf0[i], med9(xw0[i])} : {xf1[i], med9(xw1[i])};
      o = (src == 0) ? mo0[i] : mo1[i];
      if (o !== e) return i;
    end
    return (ne != no) ? mn : -1;
  endfunction

  // index of first f beat differing from "whole frames of src first, then the other"
  function automatic int f_order_bad(input int first);
    logic [WW-1:0] e[$];
    if (first == 0) begin
      foreach (xw0[i]) e.push_back(xw0[i]);
      foreach (xw1[i]) e.push_back(xw1[i]);
    end else begin
      foreach (xw1[i]) e.push_back(xw1[i]);
      foreach (xw0[i]) e.push_back(xw0[i]);
    end
    for (int i = 0; i < e.size() && i < fobs.size(); i++)
      if (fobs[i] !== e[i]) return i;
    return (e.size() != fobs.size()) ? ((e.size() < fobs.size()) ? e.size() : fobs.size()) : -1;
  endfunction

  task automatic test_reset();
    int bad;
    set_rdy(1'b0, 1'b0, 1'b0, 100);
    rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    bad = {s0_rdy, s1_rdy, f_val, r_rdy, m0_val, m1_val};
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_outputs got=%06b expected=000000 (s0_rdy s1_rdy f_val r_rdy m0_val m1_val)", bad[5:0]);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      failures++; $display("FAIL reset_state got=%0d expected=%0d", dut.state_q, ST_IDLE);
    end
`ifdef MEDIAN_ARB_STATS_EN
    checks++;
    if (frm_cnt0 !== 16'd0 || frm_cnt1 !== 16'd0) begin
      failures++; $display("FAIL reset_cnt got=%0d/%0d expected=0/0", frm_cnt0, frm_cnt1);
    end
`endif
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_single_frame();
    int b;
    set_rdy(1'b1, 1'b1, 1'b1, 100);
    do_reset();
    send_frame(0, 4, 4, 0);
    wait_out(16, 0);
    checks++;
    if (fobs.size() !== 16) begin
      failures++; $display("FAIL single_f_count got=%0d expected=16", fobs.size());
    end
    b = f_order_bad(0);
    checks++;
    if (b != -1) begin failures++; $display("FAIL single_f_data idx=%0d got_beats=%0d expected_beats=16", b, fobs.size()); end
    checks++;
    if (f_first - sof_cyc !== 1) begin
      failures++; $display("FAIL single_latency got=%0d expected=1", f_first - sof_cyc);
    end
    b = stream_bad(0);
    checks++;
    if (b != -1) begin failures++; $display("FAIL single_m0 idx=%0d got_beats=%0d expected_beats=16", b, mo0.size()); end
    checks++;
    if (m1_seen !== 1'b0) begin failures++; $display("FAIL single_m1_quiet got=1 expected=0"); end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      failures++; $display("FAIL single_idle got=%0d expected=%0d", dut.state_q, ST_IDLE);
    end
  endtask

  task automatic tie_round(input int winner, input string tag);
    int b;
    fork
      send_frame(0, 2, 2, 0);
      send_frame(1, 2, 2, 0);
    join
    wait_out(4, 4);
    b = f_order_bad(winner);
    checks++;
    if (b != -1) begin failures++; $display("FAIL %s_order idx=%0d expected_first_src=%0d", tag, b, winner); end
    b = stream_bad(0);
    checks++;
    if (b != -1) begin failures++; $display("FAIL %s_m0 idx=%0d got_beats=%0d expected_beats=%0d", tag, b, mo0.size(), xw0.size()); end
    b = stream_bad(1);
    checks++;
    if (b != -1) begin failures++; $display("FAIL %s_m1 idx=%0d got_beats=%0d expected_beats=%0d", tag, b, mo1.size(), xw1.size()); end
    clear_all();
  endtask

  task automatic test_tie();
    set_rdy(1'b1, 1'b1, 1'b1, 100);
    do_reset();
    tie_round(0, "tie_first");
    tie_round(0, "tie_second");
    send_frame(0, 1, 1, 0);
    wait_out(1, 0);
    clear_all();
    tie_round(1, "tie_after_s0");
  endtask

  task automatic test_garbage();
    int n, tot, b;
    logic [95:0] rr;
    set_rdy(1'b1, 1'b1, 1'b1, 100);
    do_reset();
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      rr = {$urandom, $urandom, $urandom};
      drive_beat(1, rr[WW-1:0], 4'($urandom_range(0, 7)), n);
      tot += n;
    end
    checks++;
    if (tot !== 3) begin failures++; $display("FAIL garbage_flush_cycles got=%0d expected=3", tot); end
    send_frame(1, 3, 2, 1);
    wait_out(0, 6);
    b = f_order_bad(1);
    checks++;
    if (b != -1) begin failures++; $display("FAIL garbage_f_stream idx=%0d got_beats=%0d expected_beats=6", b, fobs.size()); end
    b = stream_bad(1);
    checks++;
    if (b != -1) begin failures++; $display("FAIL garbage_m1 idx=%0d got_beats=%0d expected_beats=6", b, mo1.size()); end
  endtask

  task automatic test_fifo_full();
    bit done3 = 1'b0;
    int k, b;
    logic held;
    set_rdy(1'b1, 1'b0, 1'b1, 100);
    do_reset();
    send_frame(0, 1, 1, 0);
    send_frame(0, 1, 1, 0);
    fork
      begin send_frame(0, 1, 1, 0); done3 = 1'b1; end
    join_none
    repeat (15) begin @(posedge clk); #1; end
    @(negedge clk);
    held = s0_rdy;
    @(posedge clk); #1;
    checks++;
    if (done3 !== 1'b0 || held !== 1'b0 || fobs.size() !== 2) begin
      failures++;
      $display("FAIL full_hold got_done=%0d got_rdy=%0d got_fbeats=%0d expected=0/0/2", done3, held, fobs.size());
    end
    m0_rdy_man = 1'b1;
    k = 0;
    while (!done3 && k < 200) begin @(posedge clk); #1; k++; end
    wait_out(3, 0);
    checks++;
    if (done3 !== 1'b1 || fcyc.size() !== 3 || fcyc[2] <= m0_first) begin
      failures++;
      $display("FAIL full_release got_done=%0d got_fbeats=%0d first_pop_cyc=%0d expected=1/3/third_after_pop",
               done3, fcyc.size(), m0_first);
    end
    b = stream_bad(0);
    checks++;
    if (b != -1) begin failures++; $display("FAIL full_m0 idx=%0d got_beats=%0d expected_beats=3", b, mo0.size()); end
  endtask

  task automatic test_random();
    int b, e0, e1;
    f_mode = 1'b1; m_mode = 1'b1; r_pct = 50;
    do_reset();
    fork
      for (int i = 0; i < 10; i++) begin
        send_frame(0, $urandom_range(1, 3), $urandom_range(1, 3), 2);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      for (int i = 0; i < 10; i++) begin
        send_frame(1, $urandom_range(1, 3), $urandom_range(1, 3), 2);
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
    join
    wait_out(xw0.size(), xw1.size());
    b = stream_bad(0);
    checks++;
    if (b != -1) begin failures++; $display("FAIL random_m0 idx=%0d got_beats=%0d expected_beats=%0d", b, mo0.size(), xw0.size()); end
    b = stream_bad(1);
    checks++;
    if (b != -1) begin failures++; $display("FAIL random_m1 idx=%0d got_beats=%0d expected_beats=%0d", b, mo1.size(), xw1.size()); end
    e0 = 0; e1 = 0;
    foreach (mo0[i]) if (mo0[i][DW+FLG_EOF]) e0++;
    foreach (mo1[i]) if (mo1[i][DW+FLG_EOF]) e1++;
    checks++;
    if (e0 !== 10 || e1 !== 10) begin failures++; $display("FAIL random_frames got=%0d/%0d expected=10/10", e0, e1); end
`ifdef MEDIAN_ARB_STATS_EN
    checks++;
    if (frm_cnt0 !== 16'd10 || frm_cnt1 !== 16'd10) begin
      failures++; $display("FAIL random_frm_cnt got=%0d/%0d expected=10/10", frm_cnt0, frm_cnt1);
    end
`endif
    set_rdy(1'b1, 1'b1, 1'b1, 100);
  endtask

  task automatic test_reset_mid();
    int n, b;
    logic [5:0] o;
    set_rdy(1'b1, 1'b1, 1'b1, 100);
    do_reset();
    drive_beat(1, {$urandom, $urandom, 8'h5a}, 4'b1010, n);
    drive_beat(1, {$urandom, $urandom, 8'ha5}, 4'b0001, n);
    checks++;
    if (dut.state_q !== ST_GNT1) begin failures++; $display("FAIL midrst_pre got=%0d expected=%0d", dut.state_q, ST_GNT1); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    o = {s0_rdy, s1_rdy, f_val, r_rdy, m0_val, m1_val};
    checks++;
    if (o !== 6'b0 || dut.u_id_fifo.empty !== 1'b1) begin
      failures++;
      $display("FAIL midrst_outputs got=%06b empty=%0d expected=000000 empty=1", o, dut.u_id_fifo.empty);
    end
    @(posedge clk); #1;
    clear_all();
    fork
      send_frame(0, 1, 2, 0);
      send_frame(1, 1, 2, 0);
    join
    wait_out(2, 2);
    b = f_order_bad(0);
    checks++;
    if (b != -1) begin failures++; $display("FAIL midrst_tie idx=%0d expected_first_src=0", b); end
    b = stream_bad(1);
    checks++;
    if (b != -1) begin failures++; $display("FAIL midrst_m1 idx=%0d got_beats=%0d expected_beats=2", b, mo1.size()); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_tie();
    test_garbage();
    test_fifo_full();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
